// File: rtl/inst_mem_loader.sv
// Streams machine-code words into instruction RAM at consecutive addresses from 0,
// holding the CPU off until the image is complete and keeping a running checksum.
module inst_mem_loader #(
    parameter int unsigned A = 9,
    parameter int unsigned W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A:0]   Length,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [A-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic         cpu_hold,
    output logic [W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    state_e       state_q, state_d;
    logic [A-1:0] count_q, count_d;
    logic [A:0]   len_q, len_d;
    logic         wr_en_q, wr_en_d;
    logic [A-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic [W-1:0] sum_q, sum_d;
    logic         accept;
    logic         last_beat;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            len_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sum_q     <= sum_d;
        end
    end

    // count stays at Length-1 on the final beat so a full 2**A load never wraps it
    assign accept    = (state_q == S_LOAD) && in_valid;
    assign last_beat = ({1'b0, count_q} == (len_q - (A+1)'(1)));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sum_d     = sum_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    count_d = '0;
                    sum_d   = '0;
                    len_d   = Length;
                    state_d = (Length == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = in_data;
                    sum_d     = sum_q + in_data;
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD);
    assign done     = (state_q == S_DONE);
    assign cpu_hold = (state_q != S_DONE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign checksum = sum_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader; expected writes and checksum
// come from the word buffer driven into the loader.
module tb_inst_mem_loader;
    localparam int A = 9;
    localparam int W = 9;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [A:0]   Length;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic         cpu_hold;
    logic [W-1:0] checksum;

    inst_mem_loader #(.A(A), .W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Length(Length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .cpu_hold(cpu_hold), .checksum(checksum)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [W-1:0] wbuf [0:511];
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];

    always @(posedge Clk) cyc <= cyc + 1;

    // observed RAM writes, captured mid-cycle
    always @(negedge Clk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
            wq_cyc.push_back(cyc);
        end
    end

    function automatic int model_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(wbuf[i]);
        return s % (1 << W);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) wbuf[i] = W'($urandom);
    endtask

    task automatic start_load(input int len);
        Start  = 1'b1;
        Length = (A+1)'(len);
        tick();
        Start  = 1'b0;
    endtask

    task automatic noise_cycle(input logic noise);
        if (noise) begin
            Start  = 1'($urandom_range(0, 1));
            Length = (A+1)'($urandom);
        end
    endtask

    // mode 0: back-to-back, 1: one idle cycle between beats, 2: random idle gaps
    task automatic stream(input int n, input int mode, input logic noise);
        for (int i = 0; i < n; i++) begin
            if (mode == 1 && i > 0) begin
                in_valid = 1'b0; in_data = W'($urandom); noise_cycle(noise); tick();
            end
            if (mode == 2) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    in_valid = 1'b0; in_data = W'($urandom); noise_cycle(noise); tick();
                end
            end
            in_valid = 1'b1;
            in_data  = wbuf[i];
            noise_cycle(noise);
            tick();
        end
        in_valid = 1'b0;
        Start    = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; in_valid = 1'b1; in_data = W'($urandom); Length = 5;
        repeat (3) tick();
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        vectors++; if (wr_addr !== '0) begin miscompares++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        vectors++; if (wr_data !== '0) begin miscompares++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
        vectors++; if (checksum !== '0) begin miscompares++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
        clear_writes();
        Reset = 1'b0;
        repeat (3) tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_in_ready: got %b expected 0", in_ready); end
        vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL idle_cpu_hold: got %b expected 1", cpu_hold); end
        vectors++; if (wq_addr.size() != 0) begin miscompares++; $display("FAIL idle_writes: got %0d expected 0", wq_addr.size()); end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        wbuf[0] = 9'h001; wbuf[1] = 9'h049; wbuf[2] = 9'h1FF;
        clear_writes();
        start_load(3);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        stream(3, 0, 1'b0);
        tick();
        vectors++; if (wq_addr.size() != 3) begin miscompares++; $display("FAIL b2b_count: got %0d expected 3", wq_addr.size()); end
        for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
            vectors++; if (wq_addr[i] != i) begin miscompares++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", i, wq_addr[i], i); end
            vectors++; if (wq_data[i] != int'(wbuf[i])) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, wq_data[i], wbuf[i]); end
            vectors++; if (wq_cyc[i] != wq_cyc[0] + i) begin miscompares++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, wq_cyc[i], wq_cyc[0] + i); end
        end
        vectors++; if (checksum !== 9'h049) begin miscompares++; $display("FAIL b2b_checksum: got %h expected 049", checksum); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b expected 1", done); end
        vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL b2b_cpu_hold: got %b expected 0", cpu_hold); end
    endtask

    task automatic test_toggle();
        fill_random(4);
        clear_writes();
        start_load(4);
        stream(4, 1, 1'b0);
        tick();
        vectors++; if (wq_addr.size() != 4) begin miscompares++; $display("FAIL toggle_count: got %0d expected 4", wq_addr.size()); end
        for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
            vectors++; if (wq_addr[i] != i) begin miscompares++; $display("FAIL toggle_addr[%0d]: got %0d expected %0d", i, wq_addr[i], i); end
            vectors++; if (wq_data[i] != int'(wbuf[i])) begin miscompares++; $display("FAIL toggle_data[%0d]: got %h expected %h", i, wq_data[i], wbuf[i]); end
            vectors++; if (wq_cyc[i] != wq_cyc[0] + 2 * i) begin miscompares++; $display("FAIL toggle_cycle[%0d]: got %0d expected %0d", i, wq_cyc[i], wq_cyc[0] + 2 * i); end
        end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL toggle_in_ready: got %b expected 0", in_ready); end
        vectors++; if (checksum !== W'(model_sum(4))) begin miscompares++; $display("FAIL toggle_checksum: got %h expected %h", checksum, W'(model_sum(4))); end
    endtask

    task automatic test_zero_length();
        clear_writes();
        start_load(0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b expected 1", done); end
        vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL zero_cpu_hold: got %b expected 0", cpu_hold); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b expected 0", busy); end
        vectors++; if (checksum !== '0) begin miscompares++; $display("FAIL zero_checksum: got %h expected 0", checksum); end
        repeat (2) tick();
        vectors++; if (wq_addr.size() != 0) begin miscompares++; $display("FAIL zero_writes: got %0d expected 0", wq_addr.size()); end
    endtask

    task automatic test_full_length();
        int bad = 0;
        for (int i = 0; i < 512; i++) wbuf[i] = 9'h1FF;
        clear_writes();
        start_load(512);
        stream(512, 0, 1'b0);
        tick();
        vectors++; if (wq_addr.size() != 512) begin miscompares++; $display("FAIL full_count: got %0d expected 512", wq_addr.size()); end
        for (int i = 0; i < wq_addr.size(); i++) if (wq_addr[i] != i || wq_data[i] != 'h1FF) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL full_sequence: got %0d bad writes expected 0", bad); end
        vectors++; if (wq_addr.size() > 0 && wq_addr[wq_addr.size()-1] != 511) begin miscompares++; $display("FAIL full_last_addr: got %0d expected 511", wq_addr[wq_addr.size()-1]); end
        vectors++; if (checksum !== W'(model_sum(512))) begin miscompares++; $display("FAIL full_checksum: got %h expected %h", checksum, W'(model_sum(512))); end
        tick();
        vectors++; if (wr_addr !== 9'd511) begin miscompares++; $display("FAIL full_addr_hold: got %0d expected 511", wr_addr); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL full_done: got %b expected 1", done); end
    endtask

    task automatic test_reset_mid_load();
        fill_random(5);
        clear_writes();
        start_load(5);
        stream(2, 0, 1'b0);
        Reset = 1'b1;
        #1;
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL midrst_wr_en: got %b expected 0", wr_en); end
        vectors++; if (wr_addr !== '0) begin miscompares++; $display("FAIL midrst_wr_addr: got %h expected 0", wr_addr); end
        vectors++; if (wr_data !== '0) begin miscompares++; $display("FAIL midrst_wr_data: got %h expected 0", wr_data); end
        vectors++; if (busy !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b/%b expected 0/0", busy, in_ready); end
        vectors++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_hold: got %b/%b expected 1/0", cpu_hold, done); end
        vectors++; if (checksum !== '0) begin miscompares++; $display("FAIL midrst_checksum: got %h expected 0", checksum); end
        tick();
        Reset = 1'b0;
        tick();
        vectors++; if (wq_addr.size() != 1) begin miscompares++; $display("FAIL midrst_writes: got %0d expected 1", wq_addr.size()); end
        fill_random(2);
        clear_writes();
        start_load(2);
        stream(2, 0, 1'b0);
        tick();
        vectors++; if (wq_addr.size() != 2) begin miscompares++; $display("FAIL reload_count: got %0d expected 2", wq_addr.size()); end
        for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
            vectors++; if (wq_addr[i] != i || wq_data[i] != int'(wbuf[i])) begin miscompares++; $display("FAIL reload_write[%0d]: got %0d:%h expected %0d:%h", i, wq_addr[i], wq_data[i], i, wbuf[i]); end
        end
        vectors++; if (checksum !== W'(model_sum(2))) begin miscompares++; $display("FAIL reload_checksum: got %h expected %h", checksum, W'(model_sum(2))); end
    endtask

    task automatic test_ignored();
        logic [W-1:0] sum_exp;
        fill_random(6);
        sum_exp = W'(model_sum(6));
        clear_writes();
        start_load(6);
        stream(6, 2, 1'b1);
        tick();
        vectors++; if (wq_addr.size() != 6) begin miscompares++; $display("FAIL ign_count: got %0d expected 6", wq_addr.size()); end
        for (int i = 0; i < 6 && i < wq_addr.size(); i++) begin
            vectors++; if (wq_addr[i] != i || wq_data[i] != int'(wbuf[i])) begin miscompares++; $display("FAIL ign_write[%0d]: got %0d:%h expected %0d:%h", i, wq_addr[i], wq_data[i], i, wbuf[i]); end
        end
        vectors++; if (checksum !== sum_exp) begin miscompares++; $display("FAIL ign_checksum: got %h expected %h", checksum, sum_exp); end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = W'($urandom);
            tick();
            vectors++; if (in_ready !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL ign_done_ready: got %b/%b expected 0/1", in_ready, done); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (wq_addr.size() != 6) begin miscompares++; $display("FAIL ign_done_writes: got %0d expected 6", wq_addr.size()); end
        vectors++; if (checksum !== sum_exp) begin miscompares++; $display("FAIL ign_done_checksum: got %h expected %h", checksum, sum_exp); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            int n = $urandom_range(0, 40);
            int bad = 0;
            fill_random(n);
            clear_writes();
            start_load(n);
            if (n > 0) stream(n, ($urandom_range(0, 3) == 0) ? 0 : 2, 1'($urandom_range(0, 1)));
            tick();
            vectors++; if (wq_addr.size() != n) begin miscompares++; $display("FAIL rand%0d_count: got %0d expected %0d", t, wq_addr.size(), n); end
            for (int i = 0; i < wq_addr.size() && i < n; i++) if (wq_addr[i] != i || wq_data[i] != int'(wbuf[i])) bad++;
            vectors++; if (bad != 0) begin miscompares++; $display("FAIL rand%0d_writes: got %0d bad writes expected 0", t, bad); end
            vectors++; if (checksum !== W'(model_sum(n))) begin miscompares++; $display("FAIL rand%0d_checksum: got %h expected %h", t, checksum, W'(model_sum(n))); end
            vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rand%0d_status: got done=%b hold=%b busy=%b expected 1/0/0", t, done, cpu_hold, busy); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Length = '0; in_valid = 1'b0; in_data = '0;
        #1;
        test_reset();
        test_back_to_back();
        test_toggle();
        test_zero_length();
        test_full_length();
        test_reset_mid_load();
        test_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
